// File: rtl/ad9434_spi_master.sv
// AD9434 3-wire SPI bit engine: serialises 24-bit frames MSB first on CSB/SCLK/SDIO
// and, for reads, turns SDIO around to capture the trailing data byte.
//
// Ports:
//   clk, rst                         system clock, synchronous active-high reset
//   i_spi_wr_cmd / i_spi_rd_cmd      start a write / read frame (sampled in IDLE only)
//   i_spi_wr_data                    frame word latched when a command is accepted
//   o_spi_rd_data / o_spi_rd_valid   last captured read byte and its update pulse
//   o_spi_busy                       frame in progress
//   o_spi_csb, o_spi_sclk            chip select (active low), serial clock (idles low)
//   o_spi_sdio_o, o_spi_sdio_oe      SDIO drive value and drive enable
//   i_spi_sdio_i                     SDIO pad input
module ad9434_spi_master #(
    parameter int MOSI_DATA_WIDTH = 24,
    parameter int MISO_DATA_WIDTH = 8,
    parameter int CLK_DIV         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_spi_wr_cmd,
    input  logic                       i_spi_rd_cmd,
    input  logic [MOSI_DATA_WIDTH-1:0] i_spi_wr_data,
    output logic [MISO_DATA_WIDTH-1:0] o_spi_rd_data,
    output logic                       o_spi_rd_valid,
    output logic                       o_spi_busy,
    output logic                       o_spi_csb,
    output logic                       o_spi_sclk,
    output logic                       o_spi_sdio_o,
    output logic                       o_spi_sdio_oe,
    input  logic                       i_spi_sdio_i
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(MOSI_DATA_WIDTH);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(MOSI_DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } state_t;

    state_t                     state;
    logic [DW-1:0]              div_cnt;
    logic [BW-1:0]              bit_cnt;
    logic                       hi_half;
    logic                       rd_frame;
    logic [MOSI_DATA_WIDTH-1:0] tx_sr;
    logic [MISO_DATA_WIDTH-1:0] rx_sr;
    logic                       div_end;

    assign div_end = (div_cnt == DIV_LAST);

    // Bit periods whose index falls below MISO_DATA_WIDTH belong to the
    // slave on a read frame: SDIO is released and sampled there.
    function automatic logic in_rx(input logic [BW-1:0] b);
        return int'(b) < MISO_DATA_WIDTH;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            hi_half        <= 1'b0;
            rd_frame       <= 1'b0;
            tx_sr          <= '0;
            rx_sr          <= '0;
            o_spi_rd_data  <= '0;
            o_spi_rd_valid <= 1'b0;
            o_spi_busy     <= 1'b0;
            o_spi_csb      <= 1'b1;
            o_spi_sclk     <= 1'b0;
            o_spi_sdio_o   <= 1'b0;
            o_spi_sdio_oe  <= 1'b0;
        end else begin
            o_spi_rd_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (i_spi_wr_cmd || i_spi_rd_cmd) begin
                        // write has priority when both are raised together
                        rd_frame      <= ~i_spi_wr_cmd;
                        tx_sr         <= i_spi_wr_data;
                        rx_sr         <= '0;
                        div_cnt       <= '0;
                        state         <= LEAD;
                        o_spi_busy    <= 1'b1;
                        o_spi_csb     <= 1'b0;
                        o_spi_sclk    <= 1'b0;
                        o_spi_sdio_oe <= 1'b1;
                        o_spi_sdio_o  <= i_spi_wr_data[MOSI_DATA_WIDTH-1];
                    end
                end
                LEAD: begin
                    if (div_end) begin
                        div_cnt       <= '0;
                        bit_cnt       <= BIT_LAST;
                        hi_half       <= 1'b0;
                        state         <= SHIFT;
                        o_spi_sdio_oe <= ~(rd_frame && in_rx(BIT_LAST));
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (!div_end) begin
                        div_cnt <= div_cnt + 1'b1;
                    end else if (!hi_half) begin
                        div_cnt    <= '0;
                        hi_half    <= 1'b1;
                        o_spi_sclk <= 1'b1;
                    end else begin
                        // end of the high half: sample the slave, then fall
                        div_cnt    <= '0;
                        hi_half    <= 1'b0;
                        o_spi_sclk <= 1'b0;
                        if (rd_frame && in_rx(bit_cnt)) begin
                            rx_sr <= {rx_sr[MISO_DATA_WIDTH-2:0], i_spi_sdio_i};
                        end
                        if (bit_cnt == '0) begin
                            state         <= TRAIL;
                            o_spi_sdio_oe <= 1'b0;
                            o_spi_sdio_o  <= 1'b0;
                        end else begin
                            bit_cnt       <= bit_cnt - 1'b1;
                            tx_sr         <= tx_sr << 1;
                            o_spi_sdio_o  <= tx_sr[MOSI_DATA_WIDTH-2];
                            o_spi_sdio_oe <= ~(rd_frame && in_rx(bit_cnt - 1'b1));
                        end
                    end
                end
                TRAIL: begin
                    if (div_end) begin
                        div_cnt   <= '0;
                        state     <= GAP;
                        o_spi_csb <= 1'b1;
                        if (rd_frame) begin
                            o_spi_rd_data  <= rx_sr;
                            o_spi_rd_valid <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (div_end) begin
                        div_cnt    <= '0;
                        state      <= IDLE;
                        o_spi_busy <= 1'b0;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad9434_spi_master.sv
// Self-checking bench for ad9434_spi_master: a cycle-level SPI slave model and
// frame-level expectations for CLK_DIV=4 and CLK_DIV=2 instances.
module tb_ad9434_spi_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        wr1, rd1, v1, b1, csb1, sclk1, so1, oe1, si1;
    logic [23:0] wd1;
    logic [7:0]  rdd1;
    logic        wr2, rd2, v2, b2, csb2, sclk2, so2, oe2, si2;
    logic [23:0] wd2;
    logic [7:0]  rdd2;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] last_rd [2];

    ad9434_spi_master #(.CLK_DIV(4)) u_dut (
        .clk(clk), .rst(rst),
        .i_spi_wr_cmd(wr1), .i_spi_rd_cmd(rd1), .i_spi_wr_data(wd1),
        .o_spi_rd_data(rdd1), .o_spi_rd_valid(v1), .o_spi_busy(b1),
        .o_spi_csb(csb1), .o_spi_sclk(sclk1), .o_spi_sdio_o(so1),
        .o_spi_sdio_oe(oe1), .i_spi_sdio_i(si1)
    );

    ad9434_spi_master #(.CLK_DIV(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .i_spi_wr_cmd(wr2), .i_spi_rd_cmd(rd2), .i_spi_wr_data(wd2),
        .o_spi_rd_data(rdd2), .o_spi_rd_valid(v2), .o_spi_busy(b2),
        .o_spi_csb(csb2), .o_spi_sclk(sclk2), .o_spi_sdio_o(so2),
        .o_spi_sdio_oe(oe2), .i_spi_sdio_i(si2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic issue(input bit sel, input bit w, input bit r, input logic [23:0] d);
        @(negedge clk);
        if (sel) begin wr2 = w; rd2 = r; wd2 = d; end
        else begin wr1 = w; rd1 = r; wd1 = d; end
    endtask

    task automatic drop(input bit sel);
        if (sel) begin wr2 = 1'b0; rd2 = 1'b0; end
        else begin wr1 = 1'b0; rd1 = 1'b0; end
    endtask

    task automatic drive_si(input bit sel, input logic x);
        if (sel) si2 = x; else si1 = x;
    endtask

    // Called at a negedge while a frame is in progress; follows it to the
    // first idle cycle, acting as the slave and tallying frame properties.
    task automatic watch(input bit sel, input bit is_rd, input logic [23:0] d,
                         input logic [7:0] rep, input int pulse_at,
                         input int rst_at, output int gap_n);
        int cd = sel ? 2 : 4;
        int busy_n = 0, csb_lo = 0, rises = 0, oe_n = 0, vcnt = 0;
        int hi_run = 0, bad_runs = 0;
        logic [23:0] mosi = '0;
        logic [7:0]  vdata = '0, rdv;
        logic        b, c, s, o, e, v, prev = 1'b0;
        bit          aborted = 1'b0;
        gap_n = 0;
        drive_si(sel, 1'b0);
        while (1) begin
            if (sel) begin b = b2; c = csb2; s = sclk2; o = so2; e = oe2; v = v2; rdv = rdd2; end
            else begin b = b1; c = csb1; s = sclk1; o = so1; e = oe1; v = v1; rdv = rdd1; end
            if (!b) break;
            if (busy_n > 2000) begin
                chk("frame_timeout", 1, 0);
                break;
            end
            busy_n++;
            if (!c) csb_lo++; else gap_n++;
            if (!c && e) oe_n++;
            if (v) begin vcnt++; vdata = rdv; end
            if (s) hi_run++;
            if (s && !prev) begin
                rises++;
                if (e) mosi = {mosi[22:0], o};
            end
            if (!s && prev) begin
                if (hi_run != cd) bad_runs++;
                hi_run = 0;
                // period index = rises; slave owns periods 16..23 on a read
                if (is_rd && rises >= 16 && rises < 24) drive_si(sel, rep[23-rises]);
                else drive_si(sel, 1'b0);
            end
            prev = s;
            if (pulse_at > 0) begin
                if (busy_n == pulse_at) begin if (sel) wr2 = 1'b1; else wr1 = 1'b1; end
                else if (busy_n == pulse_at + 1) drop(sel);
            end
            if (rst_at > 0 && rises == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_csb", sel ? csb2 : csb1, 1);
                chk("rst_sclk", sel ? sclk2 : sclk1, 0);
                chk("rst_oe", sel ? oe2 : oe1, 0);
                chk("rst_busy", sel ? b2 : b1, 0);
                chk("rst_rd_data", sel ? rdd2 : rdd1, 0);
                chk("rst_valid", vcnt + int'(sel ? v2 : v1), 0);
                rst = 1'b0;
                last_rd[0] = '0;
                last_rd[1] = '0;
                aborted = 1'b1;
                break;
            end
            @(negedge clk);
        end
        drive_si(sel, 1'b0);
        if (!aborted) begin
            chk("busy_len", busy_n, cd * 51);
            chk("csb_low", csb_lo, cd * 50);
            chk("gap_len", gap_n, cd);
            chk("sclk_rises", rises, 24);
            chk("sclk_hi_run", bad_runs, 0);
            chk("mosi", mosi, is_rd ? {8'h00, d[23:8]} : d);
            chk("oe_cycles", oe_n, is_rd ? cd * 33 : cd * 49);
            chk("valid_cnt", vcnt, is_rd ? 1 : 0);
            if (is_rd) begin
                chk("valid_data", vdata, rep);
                last_rd[sel] = rep;
            end
            chk("rd_data", rdv, last_rd[sel]);
        end
    endtask

    task automatic frame(input bit sel, input bit w, input bit r,
                         input logic [23:0] d, input logic [7:0] rep);
        int g;
        issue(sel, w, r, d);
        @(negedge clk);
        drop(sel);
        watch(sel, r && !w, d, rep, 0, 0, g);
    endtask

    task automatic quiet(input bit sel, input string tag);
        int hits = 0;
        repeat (6) begin
            @(negedge clk);
            if (sel ? b2 : b1) hits++;
        end
        chk(tag, hits, 0);
    endtask

    initial begin
        int g, idle;
        logic [23:0] d;
        logic [7:0]  rep;
        bit sel, t;
        rst = 1'b1;
        wr1 = 0; rd1 = 0; wd1 = '0; si1 = 0;
        wr2 = 0; rd2 = 0; wd2 = '0; si2 = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (3) @(negedge clk);
        chk("reset_outs1", {rdd1, v1, b1, csb1, sclk1, so1, oe1}, 14'b0000_0000_0010_00);
        chk("reset_outs2", {rdd2, v2, b2, csb2, sclk2, so2, oe2}, 14'b0000_0000_0010_00);
        rst = 1'b0;

        frame(0, 1, 0, 24'h001418, 8'h00);
        frame(0, 0, 1, 24'h008001, 8'h6A);

        // mid-frame pulse ignored, then simultaneous commands run a write
        issue(0, 1, 0, 24'h00AA55);
        @(negedge clk);
        drop(0);
        watch(0, 0, 24'h00AA55, 8'h00, 10, 0, g);
        quiet(0, "pulse_ignored");
        frame(0, 1, 1, 24'h123456, 8'hFF);

        // held write command: three back-to-back frames
        issue(0, 1, 0, 24'h5A5A5A);
        @(negedge clk);
        for (int f = 0; f < 3; f++) begin
            if (f == 2) drop(0);
            watch(0, 0, 24'h5A5A5A, 8'h00, 0, 0, g);
            if (f < 2) begin
                idle = 0;
                while (!b1 && idle < 10) begin
                    idle++;
                    @(negedge clk);
                end
                chk("hold_idle", idle, 1);
                chk("hold_csb_gap", (g + idle) >= 5, 1);
            end
        end
        quiet(0, "hold_stops");

        // reset at the 12th SCLK rise of a read, then a clean read
        issue(0, 0, 1, 24'h80C3F0);
        @(negedge clk);
        drop(0);
        watch(0, 1, 24'h80C3F0, 8'hA5, 0, 12, g);
        quiet(0, "rst_idle");
        frame(0, 0, 1, 24'h800300, 8'h03);

        frame(1, 1, 0, 24'hFFFFFF, 8'h00);
        frame(1, 1, 0, 24'h000000, 8'h00);

        for (int i = 0; i < 8; i++) begin
            sel = (i % 3 == 2);
            t   = 1'($urandom_range(0, 1));
            d   = 24'($urandom);
            rep = 8'($urandom);
            frame(sel, !t, t, d, rep);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
